// File: rtl/neuron_pkg.sv
// Shared types and helpers for the pipelined MAC neuron and the layer blocks built on it.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned ACT_RELU  = 0;
    localparam int unsigned ACT_IDENT = 1;

    // Beats needed to walk n pairs with `lanes` multipliers per beat
    function automatic int unsigned beats(input int unsigned n, input int unsigned lanes);
        return (n + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/neuron_mac_pipe_if.sv
// Memory-side and result-side signals of one MAC neuron.
interface neuron_mac_pipe_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 8,
    parameter int unsigned LANES = 1
);
    localparam int unsigned RLW = $clog2(N) + 1;

    logic                   start;
    logic [LANES*W-1:0]     weight;
    logic [LANES*W-1:0]     inp;
    logic [RLW-1:0]         readloc;
    logic                   busy;
    logic signed [W-1:0]    ans;
    logic                   ready;

    modport master (
        output start, weight, inp,
        input  readloc, busy, ans, ready
    );

    modport slave (
        input  start, weight, inp,
        output readloc, busy, ans, ready
    );

endinterface

// File: rtl/neuron_post.sv
// Accumulator post-processing: arithmetic shift, activation, saturation to W bits.
module neuron_post
    import neuron_pkg::*;
#(
    parameter int unsigned ACCW  = 24,
    parameter int unsigned W     = 8,
    parameter int unsigned SHIFT = 9,
    parameter int unsigned ACT   = ACT_RELU
) (
    input  logic signed [ACCW-1:0] acc,
    output logic signed [W-1:0]    ans_c
);

    localparam logic signed [ACCW-1:0] MAX_V = {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MIN_V = {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [ACCW-1:0] sh_c;
    logic signed [ACCW-1:0] act_c;

    always_comb begin
        sh_c  = acc >>> SHIFT;
        act_c = sh_c;
        if (ACT == ACT_RELU && sh_c[ACCW-1]) begin
            act_c = '0;
        end
        if (act_c > MAX_V) begin
            ans_c = {1'b0, {(W-1){1'b1}}};
        end else if (act_c < MIN_V) begin
            ans_c = {1'b1, {(W-1){1'b0}}};
        end else begin
            ans_c = act_c[W-1:0];
        end
    end

endmodule

// File: rtl/neuron_mac_pipe.sv
// Pipelined multiply-accumulate neuron: LANES products per beat into a product register,
// accumulated over ceil(N/LANES) beats, then shifted, activated and saturated.
module neuron_mac_pipe
    import neuron_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 8,
    parameter int unsigned LANES = 1,
    parameter int unsigned SHIFT = 9,
    parameter int unsigned ACT   = ACT_RELU
) (
    input  logic               clk,
    input  logic               rst,
    neuron_mac_pipe_if.slave   bus
);

    localparam int unsigned BEATS = beats(N, LANES);
    localparam int unsigned ACCW  = 2*W + $clog2(N) + 1;
    localparam int unsigned RLW   = $clog2(N) + 1;
    localparam int unsigned BW    = $clog2(BEATS + 1);
    localparam int unsigned PW    = 2*W;

    state_t                 state_q, state_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [RLW-1:0]         readloc_q, readloc_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;
    logic signed [W-1:0]    ans_q, ans_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW-1:0] prod_q, prod_d;
    logic signed [ACCW-1:0] sum_c;
    logic signed [W-1:0]    post_c;

    logic signed [W-1:0]    w_l    [LANES];
    logic signed [W-1:0]    x_l    [LANES];
    logic signed [PW-1:0]   praw_l [LANES];
    logic signed [PW-1:0]   p_l    [LANES];

    // Lane k reads word readloc+k; words past the end of the vector contribute nothing
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int unsigned K = k;
        assign w_l[k]    = bus.weight[k*W +: W];
        assign x_l[k]    = bus.inp[k*W +: W];
        assign praw_l[k] = w_l[k] * x_l[k];
        assign p_l[k]    = ((32'(readloc_q) + K) < N) ? praw_l[k] : '0;
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            sum_c = sum_c + ACCW'(p_l[k]);
        end
    end

    neuron_post #(
        .ACCW  (ACCW),
        .W     (W),
        .SHIFT (SHIFT),
        .ACT   (ACT)
    ) u_post (
        .acc   (acc_q),
        .ans_c (post_c)
    );

    // Next-state and datapath control; DRAIN spends one cycle on the final add
    // and one on registering the post-processed result
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        readloc_d = readloc_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        ans_d     = ans_q;
        acc_d     = acc_q;
        prod_d    = prod_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = FETCH;
                    beat_d    = '0;
                    readloc_d = '0;
                    acc_d     = '0;
                    prod_d    = '0;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                end
            end
            FETCH: begin
                prod_d = sum_c;
                acc_d  = acc_q + prod_q;
                if (beat_q == BW'(BEATS - 1)) begin
                    state_d   = DRAIN;
                    beat_d    = '0;
                    readloc_d = '0;
                end else begin
                    beat_d    = beat_q + 1'b1;
                    readloc_d = readloc_q + RLW'(LANES);
                end
            end
            DRAIN: begin
                if (beat_q == '0) begin
                    acc_d  = acc_q + prod_q;
                    prod_d = '0;
                    beat_d = BW'(1);
                end else begin
                    state_d = DONE;
                    beat_d  = '0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    ans_d   = post_c;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            readloc_q <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            ans_q     <= '0;
            acc_q     <= '0;
            prod_q    <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            readloc_q <= readloc_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            ans_q     <= ans_d;
            acc_q     <= acc_d;
            prod_q    <= prod_d;
        end
    end

    assign bus.readloc = readloc_q;
    assign bus.busy    = busy_q;
    assign bus.ready   = ready_q;
    assign bus.ans     = ans_q;

endmodule

// File: tb/tb_neuron_mac_pipe.sv
// Directed bench: three neuron configurations share one weight/input memory and one start.
module tb_neuron_mac_pipe;
    import neuron_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    neuron_mac_pipe_if #(.N(8), .W(8), .LANES(1)) bus_a ();
    neuron_mac_pipe_if #(.N(8), .W(8), .LANES(1)) bus_b ();
    neuron_mac_pipe_if #(.N(8), .W(8), .LANES(3)) bus_c ();

    neuron_mac_pipe #(.N(8), .W(8), .LANES(1), .SHIFT(9), .ACT(ACT_RELU))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    neuron_mac_pipe #(.N(8), .W(8), .LANES(1), .SHIFT(9), .ACT(ACT_IDENT))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    neuron_mac_pipe #(.N(8), .W(8), .LANES(3), .SHIFT(9), .ACT(ACT_RELU))
        dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    logic signed [7:0] wmem [8];
    logic signed [7:0] xmem [8];

    assign bus_a.start  = start;
    assign bus_b.start  = start;
    assign bus_c.start  = start;
    assign bus_a.weight = (int'(bus_a.readloc) < 8) ? wmem[bus_a.readloc[2:0]] : 8'h7f;
    assign bus_a.inp    = (int'(bus_a.readloc) < 8) ? xmem[bus_a.readloc[2:0]] : 8'h7f;
    assign bus_b.weight = (int'(bus_b.readloc) < 8) ? wmem[bus_b.readloc[2:0]] : 8'h7f;
    assign bus_b.inp    = (int'(bus_b.readloc) < 8) ? xmem[bus_b.readloc[2:0]] : 8'h7f;

    // Out-of-range lanes see 127 on the bus so any missing mask shows up in ans
    for (genvar k = 0; k < 3; k++) begin : g_c
        logic [4:0] idx;
        assign idx = 5'(bus_c.readloc) + 5'(k);
        assign bus_c.weight[k*8 +: 8] = (idx < 5'd8) ? wmem[idx[2:0]] : 8'h7f;
        assign bus_c.inp[k*8 +: 8]    = (idx < 5'd8) ? xmem[idx[2:0]] : 8'h7f;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int mode;   // 0: all weights = wb; 1: weight[i] = i*wb
        int wb;
        int xb;
        int exp_a;  // ReLU, 1 lane
        int exp_b;  // identity, 1 lane
        int exp_c;  // ReLU, 3 lanes
    } vec_t;

    vec_t vecs [8];

    task automatic load(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            wmem[i] = (v.mode == 1) ? 8'(i * v.wb) : 8'(v.wb);
            xmem[i] = 8'(v.xb);
        end
    endtask

    // One evaluation on all three DUTs; optional extra start pulse after edge E+pulse_at
    task automatic run_vec(input vec_t v, input int pulse_at, input string tag);
        int lat_a, lat_b, lat_c;
        load(v);
        lat_a = -1; lat_b = -1; lat_c = -1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, " readloc_a beat0"}, int'(bus_a.readloc), 0);
        chk({tag, " busy_a fetch"}, int'(bus_a.busy), 1);
        chk({tag, " ready_a fetch"}, int'(bus_a.ready), 0);
        for (int j = 1; j <= 14; j++) begin
            @(posedge clk);
            #1;
            if (j < 8) chk({tag, " readloc_a"}, int'(bus_a.readloc), j);
            if (j < 3) chk({tag, " readloc_c"}, int'(bus_c.readloc), j * 3);
            if (j == 3) chk({tag, " readloc_c idle"}, int'(bus_c.readloc), 0);
            if (j == 9) begin
                chk({tag, " readloc_a drain"}, int'(bus_a.readloc), 0);
                chk({tag, " busy_a drain"}, int'(bus_a.busy), 1);
            end
            if (lat_a < 0 && bus_a.ready) lat_a = j;
            if (lat_b < 0 && bus_b.ready) lat_b = j;
            if (lat_c < 0 && bus_c.ready) lat_c = j;
            start = (j == pulse_at);
        end
        start = 1'b0;
        chk({tag, " latency_a"}, lat_a, 10);
        chk({tag, " latency_b"}, lat_b, 10);
        chk({tag, " latency_c"}, lat_c, 5);
        chk({tag, " ans_a"}, int'(bus_a.ans), v.exp_a);
        chk({tag, " ans_b"}, int'(bus_b.ans), v.exp_b);
        chk({tag, " ans_c"}, int'(bus_c.ans), v.exp_c);
        chk({tag, " busy_a done"}, int'(bus_a.busy), 0);
    endtask

    int ra, rc, ea, ec;

    initial begin
        vecs[0] = '{0,   16,  32,   8,    8,   8};
        vecs[1] = '{0,  -16,  32,   0,   -8,   0};
        vecs[2] = '{0,  127, 127, 127,  127, 127};
        vecs[3] = '{0, -128, 127,   0, -128,   0};
        vecs[4] = '{1,    8,  64,  28,   28,  28};
        vecs[5] = '{1,   -8,  64,   0,  -28,   0};
        vecs[6] = '{0,   -1,   1,   0,   -1,   0};
        vecs[7] = '{0,   64,  64,  64,   64,  64};

        rst = 1'b0;
        start = 1'b0;
        load(vecs[0]);
        #1;
        chk("reset readloc_a", int'(bus_a.readloc), 0);
        chk("reset busy_a", int'(bus_a.busy), 0);
        chk("reset ready_a", int'(bus_a.ready), 0);
        chk("reset ans_a", int'(bus_a.ans), 0);
        chk("reset ready_c", int'(bus_c.ready), 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b1;

        // IDLE holds without start
        repeat (3) @(posedge clk);
        #1 chk("idle busy_a", int'(bus_a.busy), 0);

        foreach (vecs[i]) run_vec(vecs[i], -1, $sformatf("vec%0d", i));

        // Async reset during FETCH beat 4
        load(vecs[2]);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("pre-reset readloc_a", int'(bus_a.readloc), 4);
        #2 rst = 1'b0;
        #1;
        chk("abort readloc_a", int'(bus_a.readloc), 0);
        chk("abort busy_a", int'(bus_a.busy), 0);
        chk("abort ready_a", int'(bus_a.ready), 0);
        chk("abort ans_a", int'(bus_a.ans), 0);
        chk("abort ans_b", int'(bus_b.ans), 0);
        chk("abort ans_c", int'(bus_c.ans), 0);
        @(negedge clk) rst = 1'b1;
        run_vec(vecs[0], -1, "post-reset");

        // Start pulse mid-FETCH must be ignored
        run_vec(vecs[1], 3, "pulse");

        // Start held high in DONE: back-to-back runs
        load(vecs[0]);
        ra = 0; rc = 0; ea = 0; ec = 0;
        @(negedge clk) start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            ra[i] = bus_a.ready;
            rc[i] = bus_c.ready;
            ea[i] = (i % 11 == 10);
            ec[i] = (i % 6 == 5);
            if (bus_a.ready) chk("b2b ans_a", int'(bus_a.ans), 8);
            if (bus_c.ready) chk("b2b ans_c", int'(bus_c.ans), 8);
        end
        start = 1'b0;
        chk("b2b ready_a pattern", ra, ea);
        chk("b2b ready_c pattern", rc, ec);
        repeat (14) @(posedge clk);
        #1 chk("b2b final ready_a", int'(bus_a.ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
